// File: rtl/pool_row_feeder.sv
// pool_row_feeder: turns a raster pixel stream into the row-shifter write port
// (registered byte + CE strobe) with position, pooling-window flags and a zero flush.
module pool_row_feeder #(
    parameter int DATA_W = 8,
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int POOL   = 2,
    parameter int FLUSH  = 3,
    localparam int COL_W = $clog2(WIDTH),
    localparam int ROW_W = $clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] pix_out,
    output logic              CE,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              row_last,
    output logic              win_valid,
    output logic              busy,
    output logic              done
);

    localparam int PW = (POOL  > 1) ? $clog2(POOL)  : 1;
    localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col_cnt;
    logic [ROW_W-1:0]  r_row_cnt;
    logic [PW-1:0]     r_pcol;
    logic [PW-1:0]     r_prow;
    logic [FW-1:0]     r_flush_cnt;

    logic [DATA_W-1:0] r_pix;
    logic              r_ce;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_row_last;
    logic              r_win_valid;
    logic              r_done;

    logic w_col_last;
    logic w_row_last;
    logic w_pcol_last;
    logic w_prow_last;
    logic w_flush_last;

    // Pool phase counters avoid a modulo on the position counters.
    assign w_col_last   = (r_col_cnt   == COL_W'(WIDTH - 1));
    assign w_row_last   = (r_row_cnt   == ROW_W'(HEIGHT - 1));
    assign w_pcol_last  = (r_pcol      == PW'(POOL - 1));
    assign w_prow_last  = (r_prow      == PW'(POOL - 1));
    assign w_flush_last = (r_flush_cnt == FW'(FLUSH - 1));

    assign s_ready = (r_state == S_RUN);
    assign busy    = (r_state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_col_cnt   <= '0;
            r_row_cnt   <= '0;
            r_pcol      <= '0;
            r_prow      <= '0;
            r_flush_cnt <= '0;
            r_pix       <= '0;
            r_ce        <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_row_last  <= 1'b0;
            r_win_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle; only the branch issuing
            // a pixel or the completion pulse raises them.
            r_ce        <= 1'b0;
            r_row_last  <= 1'b0;
            r_win_valid <= 1'b0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_col_cnt <= '0;
                        r_row_cnt <= '0;
                        r_pcol    <= '0;
                        r_prow    <= '0;
                    end
                end

                S_RUN: begin
                    if (s_valid) begin
                        r_pix       <= s_data;
                        r_ce        <= 1'b1;
                        r_col       <= r_col_cnt;
                        r_row       <= r_row_cnt;
                        r_row_last  <= w_col_last;
                        r_win_valid <= w_pcol_last && w_prow_last;
                        r_pcol      <= w_pcol_last ? '0 : r_pcol + 1'b1;

                        if (w_col_last) begin
                            r_col_cnt <= '0;
                            r_row_cnt <= w_row_last  ? '0 : r_row_cnt + 1'b1;
                            r_prow    <= w_prow_last ? '0 : r_prow + 1'b1;
                            if (w_row_last) begin
                                r_flush_cnt <= '0;
                                r_state     <= (FLUSH > 0) ? S_FLUSH : S_DONE;
                            end
                        end else begin
                            r_col_cnt <= r_col_cnt + 1'b1;
                        end
                    end
                end

                // col/row keep the last real position while zeros drain the shifters.
                S_FLUSH: begin
                    r_pix       <= '0;
                    r_ce        <= 1'b1;
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (w_flush_last) begin
                        r_state <= S_DONE;
                    end
                end

                // First DONE cycle lets the last strobe retire; second carries done.
                S_DONE: begin
                    if (r_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_done <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_out   = r_pix;
    assign CE        = r_ce;
    assign col       = r_col;
    assign row       = r_row;
    assign row_last  = r_row_last;
    assign win_valid = r_win_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_pool_row_feeder.sv
// Bench for pool_row_feeder: two instances (4x4 with flush 3, 2x2 with no flush)
// driven with random data and gaps and compared against an index-arithmetic model.
module tb_pool_row_feeder;

    localparam int P = 2;

    typedef struct packed {
        logic [7:0] pix;
        logic [7:0] col;
        logic [7:0] row;
        logic       rl;
        logic       wv;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       drv_start = 1'b0;
    logic       drv_valid = 1'b0;
    logic [7:0] drv_data = 8'd0;

    logic       a_start, a_valid, a_ready, a_ce, a_rl, a_wv, a_busy, a_done;
    logic [7:0] a_pix;
    logic [1:0] a_col, a_row;
    logic       b_start, b_valid, b_ready, b_ce, b_rl, b_wv, b_busy, b_done;
    logic [7:0] b_pix;
    logic [0:0] b_col, b_row;

    logic       m_ready, m_ce, m_rl, m_wv, m_busy, m_done;
    logic [7:0] m_pix, m_col, m_row;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_ce_cyc = -10;
    int done_cnt = 0;
    ev_t mon_q[$];
    ev_t exp_q[$];

    always #5 clk = ~clk;

    assign a_start = drv_start && !sel;
    assign a_valid = drv_valid && !sel;
    assign b_start = drv_start && sel;
    assign b_valid = drv_valid && sel;

    assign m_ready = sel ? b_ready : a_ready;
    assign m_ce    = sel ? b_ce    : a_ce;
    assign m_rl    = sel ? b_rl    : a_rl;
    assign m_wv    = sel ? b_wv    : a_wv;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_pix   = sel ? b_pix   : a_pix;
    assign m_col   = sel ? 8'(b_col) : 8'(a_col);
    assign m_row   = sel ? 8'(b_row) : 8'(a_row);

    pool_row_feeder #(.DATA_W(8), .WIDTH(4), .HEIGHT(4), .POOL(P), .FLUSH(3)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .s_valid(a_valid), .s_data(drv_data),
        .s_ready(a_ready), .pix_out(a_pix), .CE(a_ce), .col(a_col), .row(a_row),
        .row_last(a_rl), .win_valid(a_wv), .busy(a_busy), .done(a_done)
    );

    pool_row_feeder #(.DATA_W(8), .WIDTH(2), .HEIGHT(2), .POOL(P), .FLUSH(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .s_valid(b_valid), .s_data(drv_data),
        .s_ready(b_ready), .pix_out(b_pix), .CE(b_ce), .col(b_col), .row(b_row),
        .row_last(b_rl), .win_valid(b_wv), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_pix"},   64'(a_pix),   64'd0);
        check({tag, "_ce"},    64'(a_ce),    64'd0);
        check({tag, "_col"},   64'(a_col),   64'd0);
        check({tag, "_row"},   64'(a_row),   64'd0);
        check({tag, "_rl"},    64'(a_rl),    64'd0);
        check({tag, "_wv"},    64'(a_wv),    64'd0);
        check({tag, "_done"},  64'(a_done),  64'd0);
        check({tag, "_ready"}, 64'(a_ready), 64'd0);
        check({tag, "_busy"},  64'(a_busy),  64'd0);
    endtask

    // Monitor: capture every strobe, check pix_out holds between strobes and
    // that done follows the final strobe by exactly one cycle.
    initial begin
        logic [7:0] held;
        logic       held_ok;
        logic       prev_sel;
        ev_t        e;
        held_ok  = 1'b0;
        prev_sel = 1'b0;
        held     = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                held_ok = 1'b0;
            end else begin
                if (m_ce) begin
                    e.pix = m_pix; e.col = m_col; e.row = m_row; e.rl = m_rl; e.wv = m_wv;
                    mon_q.push_back(e);
                    last_ce_cyc = cyc;
                end else if (held_ok && prev_sel == sel) begin
                    check("pix_hold", 64'(m_pix), 64'(held));
                end
                if (m_done) begin
                    done_cnt++;
                    check("done_after_last_ce", 64'(cyc - last_ce_cyc), 64'd1);
                end
                held     = m_pix;
                held_ok  = 1'b1;
                prev_sel = sel;
            end
        end
    end

    task automatic run_frame(input bit s, input int gap_pct, input bit seq, input bit poke, input bit b2b);
        int  w, h, f, n, sent, guard, n_rl, n_wv;
        ev_t e;
        w = s ? 2 : 4;
        h = w;
        f = s ? 0 : 3;
        n = w * h;
        sent = 0;
        sel = s;
        mon_q.delete();
        exp_q.delete();
        done_cnt = 0;

        drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;
        check("start_ready", 64'(m_ready), 64'd1);

        guard = 0;
        while (sent < n && guard < 2000) begin
            guard++;
            drv_start = poke && (sent == n / 2);
            drv_valid = ($urandom_range(0, 99) >= gap_pct);
            drv_data  = seq ? 8'(sent + 1) : 8'($urandom);
            if (drv_valid && m_ready) begin
                e.pix = drv_data;
                e.col = 8'(sent % w);
                e.row = 8'(sent / w);
                e.rl  = ((sent % w) == w - 1);
                e.wv  = (((sent % w) % P) == P - 1) && (((sent / w) % P) == P - 1);
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        drv_start = 1'b0;
        check("frame_len", 64'(sent), 64'(n));
        check("ready_drop", 64'(m_ready), 64'd0);

        for (int i = 0; i < f; i++) begin
            e.pix = 8'd0; e.col = 8'(w - 1); e.row = 8'(h - 1); e.rl = 1'b0; e.wv = 1'b0;
            exp_q.push_back(e);
        end

        if (poke) begin
            drv_start = 1'b1;
            repeat (f + 2) @(posedge clk);
            #1;
            drv_start = 1'b0;
        end

        guard = 0;
        while (!m_done && done_cnt == 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("done_seen", 64'(m_done || done_cnt > 0), 64'd1);
        if (b2b) begin
            @(posedge clk); #1;
        end else begin
            repeat (4) @(posedge clk);
            #1;
        end

        check("done_once", 64'(done_cnt), 64'd1);
        check("ce_total", 64'(mon_q.size()), 64'(n + f));
        n_rl = 0;
        n_wv = 0;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (i < exp_q.size()) check($sformatf("event%0d", i), 64'(mon_q[i]), 64'(exp_q[i]));
            n_rl += int'(mon_q[i].rl);
            n_wv += int'(mon_q[i].wv);
        end
        check("row_last_count", 64'(n_rl), 64'(h));
        check("win_valid_count", 64'(n_wv), 64'(n / (P * P)));
        check("idle_after", 64'(m_busy), 64'd0);
    endtask

    task automatic abort_frame();
        int sent, guard;
        sent = 0;
        sel = 1'b0;
        done_cnt = 0;
        drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;
        drv_valid = 1'b1;
        guard = 0;
        while (sent < 7 && guard < 100) begin
            guard++;
            drv_data = 8'($urandom_range(1, 255));
            if (a_ready) sent++;
            @(posedge clk); #1;
        end
        check("abort_sent", 64'(sent), 64'd7);
        check("abort_ce_before", 64'(a_ce), 64'd1);
        rst = 1'b0;
        #1;
        check_a_zero("abort");
        drv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(a_busy), 64'd0);
    endtask

    initial begin
        #2;
        rst = 1'b0;
        drv_start = 1'b1;
        drv_valid = 1'b1;
        drv_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_a_zero("reset");
        check("reset_b_ready", 64'(b_ready), 64'd0);
        check("reset_b_busy", 64'(b_busy), 64'd0);
        drv_start = 1'b0;
        drv_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("release_busy", 64'(a_busy), 64'd0);
        check("release_ready", 64'(a_ready), 64'd0);

        run_frame(1'b0, 0,  1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 35, 1'b1, 1'b0, 1'b0);
        run_frame(1'b0, 30, 1'b0, 1'b1, 1'b1);
        run_frame(1'b0, 20, 1'b0, 1'b0, 1'b0);
        abort_frame();
        run_frame(1'b0, 25, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 0,  1'b1, 1'b0, 1'b0);
        run_frame(1'b1, 40, 1'b0, 1'b1, 1'b1);
        run_frame(1'b1, 30, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

endmodule
